// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types for the bit-serial add unit.
//   state_t : sequencing FSM encoding (IDLE, CALC, DONE).
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/serial_add_unit_fa_ha.sv
// HA_rtl / fa_ha: combinational half adder and a full adder built from two
// half adders whose carries are ORed (they can never both be 1).
//   HA_rtl ports : a, b -> sum, cout
//   fa_ha ports  : a, b, cin -> sum, cout
module HA_rtl (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule : HA_rtl

module fa_ha (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ha0_sum_s;
  logic ha0_cout_s;
  logic ha1_cout_s;

  HA_rtl u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (ha0_sum_s),
    .cout (ha0_cout_s)
  );

  HA_rtl u_ha1 (
    .a    (ha0_sum_s),
    .b    (cin),
    .sum  (sum),
    .cout (ha1_cout_s)
  );

  assign cout = ha0_cout_s | ha1_cout_s;

endmodule : fa_ha

// File: rtl/serial_add_unit.sv
// serial_add_unit: bit-serial NBITS-bit adder reusing one full adder, one bit
// per cycle LSB first. Requests and results use val/rdy handshakes.
//   clk, reset_n          : clock, async active-low reset
//   req_val/req_rdy       : request handshake, operands req_a/req_b
//   resp_val/resp_rdy     : response handshake, resp_sum/resp_cout
// resp_sum/resp_cout read as 0 whenever resp_val is low.
module serial_add_unit
  import serial_add_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [NBITS-1:0] req_a,
  input  logic [NBITS-1:0] req_b,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_sum,
  output logic             resp_cout
);

  localparam int CNT_W = $clog2(NBITS) + 1;

  state_t           state_r;
  state_t           state_next_s;
  logic [NBITS-1:0] a_sh_r;
  logic [NBITS-1:0] b_sh_r;
  logic [NBITS-1:0] sum_r;
  logic [NBITS-1:0] sum_next_s;
  logic             carry_r;
  logic [CNT_W-1:0] count_r;
  logic             req_rdy_r;
  logic             resp_val_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             req_fire_s;
  logic             resp_fire_s;
  logic             last_bit_s;

  fa_ha u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  assign req_fire_s  = req_val & req_rdy_r;
  assign resp_fire_s = resp_val_r & resp_rdy;
  assign last_bit_s  = (count_r == CNT_W'(NBITS - 1));

  // New sum bit enters at the MSB; written this way so NBITS=1 needs no slice.
  always_comb begin
    sum_next_s             = sum_r >> 1'b1;
    sum_next_s[NBITS-1]    = fa_sum_s;
  end

  // Next-state decode for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_fire_s) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        if (resp_fire_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake flags registered from the next state, so req_rdy stays low
  // through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_rdy_r  <= 1'b0;
      resp_val_r <= 1'b0;
    end else begin
      req_rdy_r  <= (state_next_s == IDLE);
      resp_val_r <= (state_next_s == DONE);
    end
  end

  // Operand shift registers, sum assembly, carry and bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh_r  <= {NBITS{1'b0}};
      b_sh_r  <= {NBITS{1'b0}};
      sum_r   <= {NBITS{1'b0}};
      carry_r <= 1'b0;
      count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_fire_s) begin
            a_sh_r  <= req_a;
            b_sh_r  <= req_b;
            sum_r   <= {NBITS{1'b0}};
            carry_r <= 1'b0;
            count_r <= {CNT_W{1'b0}};
          end
        end
        CALC: begin
          a_sh_r  <= a_sh_r >> 1'b1;
          b_sh_r  <= b_sh_r >> 1'b1;
          sum_r   <= sum_next_s;
          carry_r <= fa_cout_s;
          count_r <= count_r + CNT_W'(1);
        end
        DONE: begin
          // hold result until the consumer takes it
        end
        default: begin
          carry_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_rdy   = req_rdy_r;
  assign resp_val  = resp_val_r;
  assign resp_sum  = resp_val_r ? sum_r : {NBITS{1'b0}};
  assign resp_cout = resp_val_r & carry_r;

endmodule : serial_add_unit

// File: tb/tb_serial_add_unit.sv
module tb_serial_add_unit;

  logic       clk;
  logic       reset_n;
  logic       req_val;
  logic       req_rdy;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       resp_val;
  logic       resp_rdy;
  logic [7:0] resp_sum;
  logic       resp_cout;

  logic       n1_req_val;
  logic       n1_req_rdy;
  logic [0:0] n1_req_a;
  logic [0:0] n1_req_b;
  logic       n1_resp_val;
  logic       n1_resp_rdy;
  logic [0:0] n1_resp_sum;
  logic       n1_resp_cout;

  logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  int vectors = 0;
  int errors  = 0;

  serial_add_unit #(.NBITS(8)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_sum(resp_sum), .resp_cout(resp_cout)
  );

  serial_add_unit #(.NBITS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_val(n1_req_val), .req_rdy(n1_req_rdy), .req_a(n1_req_a), .req_b(n1_req_b),
    .resp_val(n1_resp_val), .resp_rdy(n1_resp_rdy),
    .resp_sum(n1_resp_sum), .resp_cout(n1_resp_cout)
  );

  fa_ha u_fa (.a(fa_a), .b(fa_b), .cin(fa_cin), .sum(fa_sum), .cout(fa_cout));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request, optionally changes operands after acceptance and
  // stalls the response; reports what it observed. Ends at the negedge after
  // the response handshake edge.
  task automatic do_transaction(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] a2, input logic [7:0] b2,
                                input int stall,
                                output int lat, output logic [7:0] sum,
                                output logic cout, output bit rdy_seen,
                                output bit stable);
    int wait_cnt;
    lat = -1; rdy_seen = 1'b0; stable = 1'b1; sum = 8'h00; cout = 1'b0;
    @(negedge clk);
    wait_cnt = 0;
    while (req_rdy !== 1'b1 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    req_a = a; req_b = b; req_val = 1'b1; resp_rdy = 1'b0;
    @(posedge clk);                       // E0
    @(negedge clk);
    req_val = 1'b0; req_a = a2; req_b = b2;
    if (req_rdy !== 1'b0) rdy_seen = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_val === 1'b1) begin
        lat = k;
        break;
      end
      if (req_rdy !== 1'b0) rdy_seen = 1'b1;
    end
    if (req_rdy !== 1'b0) rdy_seen = 1'b1;
    sum = resp_sum; cout = resp_cout;
    for (int s = 0; s < stall; s++) begin
      req_val = 1'b1; req_a = 8'h11; req_b = 8'h22;
      @(posedge clk);
      @(negedge clk);
      if (resp_val !== 1'b1 || resp_sum !== sum || resp_cout !== cout ||
          req_rdy !== 1'b0) stable = 1'b0;
    end
    req_val = 1'b0;
    resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_val = 1'b0; resp_rdy = 1'b0; req_a = 8'h00; req_b = 8'h00;
    n1_req_val = 1'b0; n1_resp_rdy = 1'b0; n1_req_a = 1'b0; n1_req_b = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (resp_val !== 1'b0 || resp_sum !== 8'h00 || resp_cout !== 1'b0 || req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: val=%b sum=%h cout=%b rdy=%b, want 0/00/0/0",
               resp_val, resp_sum, resp_cout, req_rdy);
    end
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: req_rdy=%b want 1", req_rdy);
    end
    begin
      bit saw_val = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (resp_val !== 1'b0) saw_val = 1'b1;
      end
      vectors++;
      if (saw_val) begin
        errors++;
        $display("FAIL idle_no_resp: resp_val rose with no request, want 0");
      end
    end
  endtask

  task automatic test_fa_ha();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] exp;
      v = 3'(i);
      fa_a = v[0]; fa_b = v[1]; fa_cin = v[2];
      exp = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
      #1;
      vectors++;
      if ({fa_cout, fa_sum} !== exp) begin
        errors++;
        $display("FAIL fa_ha_%0d: {cout,sum}=%b%b want %b", i, fa_cout, fa_sum, exp);
      end
    end
  endtask

  task automatic test_basic_latency();
    int lat; logic [7:0] sum; logic cout; bit rdy_seen; bit stable;
    do_transaction(8'h5A, 8'h33, 8'h5A, 8'h33, 0, lat, sum, cout, rdy_seen, stable);
    vectors++;
    if (lat !== 8) begin
      errors++; $display("FAIL latency: got %0d cycles want 8", lat);
    end
    vectors++;
    if (sum !== 8'h8D || cout !== 1'b0) begin
      errors++; $display("FAIL add_5A_33: sum=%h cout=%b want 8D/0", sum, cout);
    end
    vectors++;
    if (rdy_seen) begin
      errors++; $display("FAIL rdy_busy: req_rdy=1 during CALC/DONE want 0");
    end
  endtask

  task automatic test_ripple();
    int lat; logic [7:0] sum; logic cout; bit rdy_seen; bit stable;
    do_transaction(8'hFF, 8'h01, 8'hFF, 8'h01, 0, lat, sum, cout, rdy_seen, stable);
    vectors++;
    if (sum !== 8'h00 || cout !== 1'b1 || lat !== 8) begin
      errors++; $display("FAIL add_FF_01: sum=%h cout=%b lat=%0d want 00/1/8", sum, cout, lat);
    end
    do_transaction(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, lat, sum, cout, rdy_seen, stable);
    vectors++;
    if (sum !== 8'hFE || cout !== 1'b1 || lat !== 8) begin
      errors++; $display("FAIL add_FF_FF: sum=%h cout=%b lat=%0d want FE/1/8", sum, cout, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] sum; logic cout; bit rdy_seen; bit stable;
    do_transaction(8'h80, 8'h80, 8'h80, 8'h80, 5, lat, sum, cout, rdy_seen, stable);
    vectors++;
    if (sum !== 8'h00 || cout !== 1'b1 || lat !== 8) begin
      errors++; $display("FAIL add_80_80: sum=%h cout=%b lat=%0d want 00/1/8", sum, cout, lat);
    end
    vectors++;
    if (!stable) begin
      errors++; $display("FAIL stall_stable: outputs changed or req accepted during stall, want stable");
    end
    vectors++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      errors++; $display("FAIL after_drain: val=%b rdy=%b want 0/1", resp_val, req_rdy);
    end
    do_transaction(8'h01, 8'h01, 8'h01, 8'h01, 0, lat, sum, cout, rdy_seen, stable);
    vectors++;
    if (sum !== 8'h02 || cout !== 1'b0 || lat !== 8) begin
      errors++; $display("FAIL add_01_01: sum=%h cout=%b lat=%0d want 02/0/8", sum, cout, lat);
    end
  endtask

  task automatic test_operand_capture();
    int lat; logic [7:0] sum; logic cout; bit rdy_seen; bit stable;
    do_transaction(8'h0F, 8'h01, 8'hAA, 8'h55, 0, lat, sum, cout, rdy_seen, stable);
    vectors++;
    if (sum !== 8'h10 || cout !== 1'b0) begin
      errors++; $display("FAIL operand_capture: sum=%h cout=%b want 10/0", sum, cout);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat; logic [7:0] sum; logic cout; bit rdy_seen; bit stable; bit saw_val;
    @(negedge clk);
    req_a = 8'h12; req_b = 8'h34; req_val = 1'b1; resp_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b0 || resp_sum !== 8'h00) begin
      errors++; $display("FAIL mid_reset: val=%b rdy=%b sum=%h want 0/0/00", resp_val, req_rdy, resp_sum);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_rdy !== 1'b1) begin
      errors++; $display("FAIL mid_reset_rdy: req_rdy=%b want 1", req_rdy);
    end
    saw_val = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_val !== 1'b0) saw_val = 1'b1;
    end
    vectors++;
    if (saw_val) begin
      errors++; $display("FAIL aborted_resp: resp_val rose after abort, want 0");
    end
    do_transaction(8'h00, 8'h00, 8'h00, 8'h00, 0, lat, sum, cout, rdy_seen, stable);
    vectors++;
    if (sum !== 8'h00 || cout !== 1'b0 || lat !== 8) begin
      errors++; $display("FAIL add_00_00: sum=%h cout=%b lat=%0d want 00/0/8", sum, cout, lat);
    end
  endtask

  task automatic test_nbits1();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      @(negedge clk);
      n1_req_a = v[0]; n1_req_b = v[1]; n1_req_val = 1'b1; n1_resp_rdy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n1_req_val = 1'b0;
      vectors++;
      if (n1_resp_val !== 1'b0 || n1_req_rdy !== 1'b0) begin
        errors++; $display("FAIL n1_calc_%0d: val=%b rdy=%b want 0/0", i, n1_resp_val, n1_req_rdy);
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (n1_resp_val !== 1'b1 || n1_resp_sum !== (v[0] ^ v[1]) || n1_resp_cout !== (v[0] & v[1])) begin
        errors++;
        $display("FAIL n1_add_%0d: val=%b sum=%b cout=%b want 1/%b/%b",
                 i, n1_resp_val, n1_resp_sum, n1_resp_cout, v[0] ^ v[1], v[0] & v[1]);
      end
      n1_resp_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n1_resp_rdy = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_fa_ha();
    test_basic_latency();
    test_ripple();
    test_backpressure();
    test_operand_capture();
    test_reset_mid_calc();
    test_nbits1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_serial_add_unit
